// File: rtl/axis_video_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module : axis_video_sink_pkg
// Brief  : Shared state, beat and depth definitions for the video stream sink.
// Rev    : 1.0
// ============================================================================
package axis_video_sink_pkg;

  localparam int SINK_FIFO_DEPTH = 16;
  localparam int SINK_DATA_W     = 24;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ARMED  = 2'd1,
    RUN    = 2'd2
  } sink_state_t;

  typedef struct packed {
    logic                   tuser;
    logic                   tlast;
    logic [SINK_DATA_W-1:0] tdata;
  } sink_beat_t;

endpackage
`default_nettype wire

// File: rtl/axis_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : axis_sync_fifo
// Brief  : Single-clock FIFO, extra-MSB pointers, synchronous flush.
// Rev    : 1.0
// ============================================================================
module axis_sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;
  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = flush ? '0 : wptr_q + (AW+1)'(do_push);
    rptr_d  = flush ? '0 : rptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/axis_video_sink.sv
`default_nettype none
// ============================================================================
// Module : axis_video_sink
// Brief  : AXI4-Stream video sink locked to timing frame start, with integrity
//          checks. STARSOC_SINK_STATS_EN enables the saturating err_count.
// Rev    : 1.0
// ============================================================================
module axis_video_sink
  import axis_video_sink_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = SINK_FIFO_DEPTH
) (
  input  logic              pixel_clk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tuser,
  input  logic              s_tlast,
  output logic              s_tready,
  input  logic              active_video,
  input  logic              vblank,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_active,
  output logic              locked,
  output logic              underflow,
  output logic              sof_err,
  output logic              eol_err,
  output logic [15:0]       err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_ACTIVE - 1);

  logic              rst_meta_q, rst_n_q;
  sink_state_t       state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              armed_q, armed_d;
  logic              vblank_q;
  logic              tready_q, tready_d;
  logic              locked_q, locked_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              vid_active_q;
  logic              uf_q, uf_d, sof_q, sof_d, eol_q, eol_d;

  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [AW:0]       fifo_count, occ_d;
  logic              h_tuser, h_tlast;
  logic [DATA_W-1:0] h_data;
  logic              accept, take;

  // Reset asserts immediately and releases two edges later on the clock.
  always_ff @(posedge pixel_clk or negedge aresetn) begin
    if (!aresetn) {rst_n_q, rst_meta_q} <= 2'b00;
    else          {rst_n_q, rst_meta_q} <= {rst_meta_q, 1'b1};
  end

  axis_sync_fifo #(.WIDTH(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (pixel_clk),
    .rst_n (rst_n_q),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata ({s_tuser, s_tlast, s_tdata}),
    .pop   (fifo_pop),
    .rdata ({h_tuser, h_tlast, h_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    accept     = s_tvalid && tready_q;
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    armed_d    = armed_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    take       = 1'b0;
    uf_d       = 1'b0;
    sof_d      = 1'b0;
    eol_d      = 1'b0;
    vid_data_d = '0;

    case (state_q)
      SEARCH: begin
        if (accept && s_tuser) begin
          fifo_push = !fifo_full;
          state_d   = ARMED;
          armed_d   = 1'b0;
        end
      end
      ARMED: begin
        fifo_push = accept && !fifo_full;
        if (vblank_q && !vblank) armed_d = 1'b1;
        take = armed_q && active_video;
      end
      RUN: begin
        fifo_push = accept && !fifo_full;
        take      = active_video;
      end
      default: state_d = SEARCH;
    endcase

    // Frame start is treated as the pop of pixel (0,0); counters are zero in ARMED.
    if (take) begin
      fifo_pop = !fifo_empty;
      if (fifo_empty)                                 uf_d  = 1'b1;
      else if (h_tuser != ((col_q == '0) && (row_q == '0))) sof_d = 1'b1;
      else if (h_tlast != (col_q == COL_LAST))        eol_d = 1'b1;

      if (uf_d || sof_d || eol_d) begin
        fifo_flush = 1'b1;
        state_d    = SEARCH;
        col_d      = '0;
        row_d      = '0;
        armed_d    = 1'b0;
      end else begin
        vid_data_d = h_data;
        state_d    = RUN;
        armed_d    = 1'b0;
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = ARMED;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end

    // Ready reflects next-cycle occupancy, so a pop never reopens a full FIFO early.
    occ_d    = fifo_flush ? '0 : fifo_count + (AW+1)'(fifo_push) - (AW+1)'(fifo_pop);
    tready_d = (state_d == SEARCH) || (occ_d != (AW+1)'(FIFO_DEPTH));

    // Lock survives the ARMED gap between good frames and drops on resync.
    if (state_d == RUN)         locked_d = 1'b1;
    else if (state_d == SEARCH) locked_d = 1'b0;
    else                        locked_d = locked_q;
  end

  always_ff @(posedge pixel_clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q      <= SEARCH;
      col_q        <= '0;
      row_q        <= '0;
      armed_q      <= 1'b0;
      vblank_q     <= 1'b0;
      tready_q     <= 1'b0;
      locked_q     <= 1'b0;
      vid_data_q   <= '0;
      vid_active_q <= 1'b0;
      uf_q         <= 1'b0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      armed_q      <= armed_d;
      vblank_q     <= vblank;
      tready_q     <= tready_d;
      locked_q     <= locked_d;
      vid_data_q   <= vid_data_d;
      vid_active_q <= active_video;
      uf_q         <= uf_d;
      sof_q        <= sof_d;
      eol_q        <= eol_d;
    end
  end

`ifdef STARSOC_SINK_STATS_EN
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if ((uf_d || sof_d || eol_d) && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge pixel_clk or negedge rst_n_q) begin
    if (!rst_n_q) err_count_q <= 16'h0000;
    else          err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  assign err_count = 16'h0000;
`endif

  assign s_tready   = tready_q;
  assign vid_data   = vid_data_q;
  assign vid_active = vid_active_q;
  assign locked     = locked_q;
  assign underflow  = uf_q;
  assign sof_err    = sof_q;
  assign eol_err    = eol_q;

endmodule
`default_nettype wire
